// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - shared tag type, defaults and producer test for the hazard unit
//
// Contents:
//   STAGES_DEF, LOAD_STAGE_DEF : default pipeline depth and first load-ready stage
//   TAG_AW                     : register index width held in a tag (supports NREG <= 256)
//   tag_t                      : one in-flight stage entry {valid, dst, wr_en, is_load}
//   writes_reg()               : true when a tag is a live producer of a non-zero register
package pipe_hazard_pkg;

    localparam int STAGES_DEF     = 3;
    localparam int LOAD_STAGE_DEF = 1;
    localparam int TAG_AW         = 8;

    typedef struct packed {
        logic              valid;
        logic [TAG_AW-1:0] dst;
        logic              wr_en;
        logic              is_load;
    } tag_t;

    // Register 0 is hard-wired, so a write to it never produces a value.
    function automatic logic writes_reg(input tag_t t, input logic [TAG_AW-1:0] r);
        return t.valid && t.wr_en && (t.dst == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// rtl/hazard_tag_stage.sv - one slot of the in-flight destination tag pipeline
//
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, clears the slot
//   kill  : load a bubble instead of d (valid forced to 0)
//   d     : tag arriving from the previous stage (or decode)
//   q     : tag currently held in this stage
module hazard_tag_stage
    import pipe_hazard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic kill,
    input  tag_t d,
    output tag_t q
);

    tag_t r_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag <= '0;
        end else begin
            r_tag <= d;
            if (kill) begin
                r_tag.valid <= 1'b0;
            end
        end
    end

    assign q = r_tag;

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - operand forwarding and load-use stall detection
//
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   id_valid, flush               : decode holds an instruction / kill decode and EX entry
//   id_rs, id_rt, id_rs_used, id_rt_used : decode source registers and their use flags
//   id_dst, id_wr_en, id_is_load  : decode destination description
//   stage_result                  : per-stage result bus, slice i belongs to stage i
//   fwd_a_hit/fwd_a_data          : forward for source rs
//   fwd_b_hit/fwd_b_data          : forward for source rt
//   stall                         : load-use stall (combinational)
//   stall_count                   : saturating count of stall cycles
module pipe_hazard_unit
    import pipe_hazard_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int NREG       = 32,
    parameter  int STAGES     = STAGES_DEF,
    parameter  int LOAD_STAGE = LOAD_STAGE_DEF,
    localparam int REG_AW     = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic                     flush,
    input  logic [REG_AW-1:0]        id_rs,
    input  logic [REG_AW-1:0]        id_rt,
    input  logic                     id_rs_used,
    input  logic                     id_rt_used,
    input  logic [REG_AW-1:0]        id_dst,
    input  logic                     id_wr_en,
    input  logic                     id_is_load,
    input  logic [STAGES*DATA_W-1:0] stage_result,
    output logic                     fwd_a_hit,
    output logic                     fwd_b_hit,
    output logic [DATA_W-1:0]        fwd_a_data,
    output logic [DATA_W-1:0]        fwd_b_data,
    output logic                     stall,
    output logic [15:0]              stall_count
);

    tag_t              w_tag_d [STAGES];
    tag_t              w_tag_q [STAGES];
    logic [STAGES-1:0] w_kill;
    logic [TAG_AW-1:0] w_rs;
    logic [TAG_AW-1:0] w_rt;
    logic              w_a_match;
    logic              w_a_ready;
    logic              w_b_match;
    logic              w_b_ready;
    logic [DATA_W-1:0] w_a_sel;
    logic [DATA_W-1:0] w_b_sel;
    logic              w_stall;
    logic [15:0]       r_stall_count;

    assign w_rs = TAG_AW'(id_rs);
    assign w_rt = TAG_AW'(id_rt);

    // Stage 0 takes decode (bubble on stall/flush); stage 1 is also killed on
    // flush so the instruction leaving EX never reaches a later stage.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_tag_d[g] = '{valid: id_valid, dst: TAG_AW'(id_dst),
                                  wr_en: id_wr_en, is_load: id_is_load};
            assign w_kill[g]  = w_stall | flush;
        end else begin : g_body
            assign w_tag_d[g] = w_tag_q[g-1];
            assign w_kill[g]  = (g == 1) ? flush : 1'b0;
        end

        hazard_tag_stage u_stage (
            .clk   (clk),
            .reset (reset),
            .kill  (w_kill[g]),
            .d     (w_tag_d[g]),
            .q     (w_tag_q[g])
        );
    end

    // Scan oldest to youngest so the youngest producer is the last one written.
    always_comb begin
        w_a_match = 1'b0;
        w_a_ready = 1'b0;
        w_a_sel   = '0;
        w_b_match = 1'b0;
        w_b_ready = 1'b0;
        w_b_sel   = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (writes_reg(w_tag_q[i], w_rs)) begin
                w_a_match = 1'b1;
                w_a_ready = !w_tag_q[i].is_load || (i >= LOAD_STAGE);
                w_a_sel   = stage_result[i*DATA_W +: DATA_W];
            end
            if (writes_reg(w_tag_q[i], w_rt)) begin
                w_b_match = 1'b1;
                w_b_ready = !w_tag_q[i].is_load || (i >= LOAD_STAGE);
                w_b_sel   = stage_result[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_stall = !reset && id_valid && !flush &&
                     ((id_rs_used && w_a_match && !w_a_ready) ||
                      (id_rt_used && w_b_match && !w_b_ready));

    assign fwd_a_hit  = !reset && id_rs_used && w_a_match && w_a_ready;
    assign fwd_b_hit  = !reset && id_rt_used && w_b_match && w_b_ready;
    assign fwd_a_data = fwd_a_hit ? w_a_sel : '0;
    assign fwd_b_data = fwd_b_hit ? w_b_sel : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall       = w_stall;
    assign stall_count = r_stall_count;

endmodule
